dcache_ctrl: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache placed directly downstream of the pipelined CPU's MEM stage. It replaces the single-cycle data memory with a front end to a slow, handshaked backing memory. CPU requests come from the MEM stage: address = ALU result, write data = forwarded rt value, and MemRead/MemWrite. The block returns read data and a stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while a miss or write-through is outstanding.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_array.sv | 52 +++++
 rtl/dcache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// ============================================================================
// Module      : dcache_pkg
// Description : Shared FSM encoding, counter width and geometry helpers for
//               the direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_MISS = 2'd1;
    localparam logic [1:0] S_WR_THRU = 2'd2;

    localparam int CNT_W = 16;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Word addressing drops two byte-offset bits from the 32-bit address.
    function automatic int tag_w(input int lines);
        return 30 - $clog2(lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
// Module      : dcache_array
// Description : LINES x {valid, tag, data} storage with one combinational
//               read port and one synchronous write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data contents are don't-care until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-through no-write-allocate data cache
//               front end with pipeline stall and hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cpu_read_i,
    input  logic             cpu_write_i,
    input  logic [31:0]      cpu_addr_i,
    input  logic [31:0]      cpu_wdata_i,
    output logic [31:0]      cpu_rdata_o,
    output logic             stall_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [31:0]      mem_rdata_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    logic [1:0]       r_state;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic             w_idle;
    logic [IDX_W-1:0] w_rd_idx;
    logic [TAG_W-1:0] w_cmp_tag;
    logic             w_line_valid;
    logic [TAG_W-1:0] w_line_tag;
    logic [31:0]      w_line_data;
    logic             w_hit;
    logic             w_ack;
    logic             w_fill;
    logic             w_wupd;
    logic             w_unused_addr;

    assign w_unused_addr = &{1'b0, cpu_addr_i[1:0]};

    // While busy the array is looked up with the latched address so that
    // the write-through can decide at ack time whether the line is present.
    assign w_idle    = (r_state == S_IDLE);
    assign w_rd_idx  = w_idle ? cpu_addr_i[IDX_W+1:2]  : r_addr[IDX_W+1:2];
    assign w_cmp_tag = w_idle ? cpu_addr_i[31:IDX_W+2] : r_addr[31:IDX_W+2];
    assign w_hit     = w_line_valid && (w_line_tag == w_cmp_tag);
    assign w_ack     = mem_ack_i && r_mem_req;
    assign w_fill    = (r_state == S_RD_MISS) && w_ack;
    assign w_wupd    = (r_state == S_WR_THRU) && w_ack && w_hit;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_rd_idx   (w_rd_idx),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_fill || w_wupd),
        .i_wr_idx   (r_addr[IDX_W+1:2]),
        .i_wr_tag   (r_addr[31:IDX_W+2]),
        .i_wr_data  (w_fill ? mem_rdata_i : r_wdata)
    );

    assign stall_o = (w_idle && (cpu_write_i || (cpu_read_i && !w_hit)))
                   || (!w_idle && !w_ack);

    always_comb begin
        cpu_rdata_o = 32'h0;
        if (w_idle && cpu_read_i && !cpu_write_i && w_hit) begin
            cpu_rdata_o = w_line_data;
        end else if (w_fill) begin
            cpu_rdata_o = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_write_i) begin
                        r_state   <= S_WR_THRU;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_addr    <= {cpu_addr_i[31:2], 2'b00};
                        r_wdata   <= cpu_wdata_i;
                    end else if (cpu_read_i) begin
                        if (w_hit) begin
                            if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
                        end else begin
                            r_state   <= S_RD_MISS;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_addr    <= {cpu_addr_i[31:2], 2'b00};
                        end
                    end
                end
                S_RD_MISS, S_WR_THRU: begin
                    if (w_ack) begin
                        r_state   <= S_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_addr    <= 32'h0;
                        r_wdata   <= 32'h0;
                        if (r_state == S_RD_MISS && r_miss_cnt != '1) begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign hit_cnt_o   = r_hit_cnt;
    assign miss_cnt_o  = r_miss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Directed plus randomized bench for dcache_ctrl against a
//               line-level cache model and a backing-memory map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;

    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_read_i = 1'b0;
    logic        cpu_write_i = 1'b0;
    logic [31:0] cpu_addr_i = 32'h0;
    logic [31:0] cpu_wdata_i = 32'h0;
    logic [31:0] cpu_rdata_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(LINES)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_read_i  (cpu_read_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: one word per line, keyed by word index and tag.
    bit          m_valid [LINES];
    logic [25:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] bmem    [logic [31:0]];
    int unsigned m_hits   = 0;
    int unsigned m_misses = 0;

    function automatic logic [31:0] sat16(input int unsigned v);
        return (v > 65535) ? 32'h0000_FFFF : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_counters();
        chk("hit_cnt",  {16'h0, hit_cnt_o},  sat16(m_hits));
        chk("miss_cnt", {16'h0, miss_cnt_o}, sat16(m_misses));
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
        logic [31:0] wa;
        int          idx;
        logic [25:0] tg;
        bit          hit;
        logic [31:0] ack_data;
        wa  = {addr[31:2], 2'b00};
        idx = int'(addr[5:2]);
        tg  = addr[31:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        ack_data = 32'h0;
        cpu_read_i  = rd;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        @(negedge clk);
        if (!rd && !wr) begin
            chk("idle_stall", stall_o, 0);
            chk("idle_rdata", cpu_rdata_o, 0);
            @(posedge clk); #1;
            return;
        end
        if (!wr && hit) begin
            chk("hit_stall", stall_o, 0);
            chk("hit_data", cpu_rdata_o, m_data[idx]);
            chk("hit_req", mem_req_o, 0);
            @(posedge clk); #1;
            m_hits++;
            cpu_read_i = 1'b0;
            return;
        end
        chk("detect_stall", stall_o, 1);
        chk("detect_req", mem_req_o, 0);
        @(posedge clk); #1;
        if (!wr) begin
            ack_data = bmem.exists(wa) ? bmem[wa] : $urandom;
            bmem[wa] = ack_data;
        end
        for (int k = 0; k <= lat; k++) begin
            mem_ack_i   = (k == lat);
            mem_rdata_i = (k == lat) ? ack_data : $urandom;
            @(negedge clk);
            chk("busy_req", mem_req_o, 1);
            chk("busy_we", mem_we_o, wr);
            chk("busy_addr", mem_addr_o, wa);
            if (wr) chk("busy_wdata", mem_wdata_o, wd);
            chk("busy_stall", stall_o, (k != lat));
            if (!wr && k == lat) chk("miss_data", cpu_rdata_o, ack_data);
            @(posedge clk); #1;
        end
        mem_ack_i   = 1'b0;
        cpu_read_i  = 1'b0;
        cpu_write_i = 1'b0;
        if (wr) begin
            bmem[wa] = wd;
            if (hit) m_data[idx] = wd;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = ack_data;
            m_misses++;
        end
        chk("req_drop", mem_req_o, 0);
        chk_counters();
    endtask

    task automatic idle_cycle(input bit stray);
        mem_ack_i   = stray;
        mem_rdata_i = $urandom;
        @(negedge clk);
        chk("stray_stall", stall_o, 0);
        chk("stray_req", mem_req_o, 0);
        chk("stray_rdata", cpu_rdata_o, 0);
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_stall", stall_o, 0);
        chk_counters();
        @(posedge clk); #1;

        bmem[32'h40] = 32'hDEADBEEF;
        do_op(1, 0, 32'h40, 0, 3);
        chk("cold_miss_cnt", {16'h0, miss_cnt_o}, 1);
        do_op(1, 0, 32'h40, 0, 0);
        chk("cold_hit_cnt", {16'h0, hit_cnt_o}, 1);

        do_op(0, 1, 32'h40, 32'h12345678, 2);
        do_op(1, 0, 32'h40, 0, 0);

        do_op(0, 1, 32'h80, 32'h5, 0);
        do_op(1, 0, 32'h80, 0, 1);
        chk("wmiss_miss_cnt", {16'h0, miss_cnt_o}, 2);

        do_op(1, 0, 32'h00, 0, 0);
        do_op(1, 0, 32'h40, 0, 1);
        do_op(1, 0, 32'h00, 0, 2);
        chk("conflict_miss_cnt", {16'h0, miss_cnt_o}, 5);
        chk("conflict_hit_cnt",  {16'h0, hit_cnt_o},  2);

        idle_cycle(1'b1);
        idle_cycle(1'b0);
        do_op(1, 1, 32'h0000_0003, 32'hA5A5_0001, 1);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            op = $urandom_range(0, 9);
            if (op == 0)      idle_cycle($urandom_range(0, 1) == 1);
            else if (op <= 6) do_op(1, 0, a, 0, $urandom_range(0, 3));
            else if (op <= 8) do_op(0, 1, a, $urandom, $urandom_range(0, 3));
            else              do_op(1, 1, a, $urandom, $urandom_range(0, 3));
        end

        // Abandon an in-flight miss by resetting before the ack arrives.
        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h0000_FFC0;
        @(negedge clk);
        chk("mid_detect_stall", stall_o, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_busy_req", mem_req_o, 1);
        @(posedge clk); #1;
        rst_i      = 1'b1;
        cpu_read_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_reset();
        chk("mid_rst_req", mem_req_o, 0);
        chk("mid_rst_stall", stall_o, 0);
        chk_counters();
        do_op(1, 0, 32'h40, 0, 1);
        chk("post_rst_miss_cnt", {16'h0, miss_cnt_o}, 1);

        cpu_read_i = 1'b1;
        cpu_addr_i = 32'h40;
        repeat (66000) @(posedge clk);
        #1;
        chk("sat_stall", stall_o, 0);
        cpu_read_i = 1'b0;
        m_hits += 66000;
        chk_counters();
        chk("sat_hit_cnt", {16'h0, hit_cnt_o}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
